// File: rtl/openmips_pkg.sv
// Shared constants for the OpenMIPS pipeline: NOP payload fields and the
// state encoding of the EX/MEM skid register.
package openmips_pkg;

    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a one-entry skid buffer and registered ex_ready.
// Optional HI/LO multiply-accumulate feedback path is built when EX_MEM_MADD_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, mem_* at NOP, ex_ready high
// ST_FULL  | main register valid, ex_ready high
// ST_SKID  | main and skid valid, ex_ready low
module ex_mem_skid
    import openmips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic                  ex_hold,
    input  logic [2*DATA_W-1:0]   ex_hilo_temp,
    input  logic [CNT_W-1:0]      ex_cnt,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } payload_t;

    localparam payload_t NOP_PAYLOAD = '{
        wd:    ADDR_W'(NOP_REG_ADDR),
        wreg:  WRITE_DISABLE,
        wdata: DATA_W'(ZERO_WORD),
        hi:    DATA_W'(ZERO_WORD),
        lo:    DATA_W'(ZERO_WORD),
        whilo: WRITE_DISABLE
    };

    skid_state_e state_q, state_d;
    payload_t    main_q, main_d;
    payload_t    skid_q, skid_d;
    logic        ex_ready_q, ex_ready_d;
    payload_t    ex_pl;
    logic        in_fire;
    logic        out_fire;

    assign ex_pl = '{
        wd:    ex_wd,
        wreg:  ex_wreg,
        wdata: ex_wdata,
        hi:    ex_hi,
        lo:    ex_lo,
        whilo: ex_whilo
    };

    assign in_fire  = ex_valid && ex_ready_q;
    assign out_fire = (state_q != ST_EMPTY) && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= NOP_PAYLOAD;
            skid_q     <= NOP_PAYLOAD;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            ex_ready_q <= ex_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_PAYLOAD;
            skid_d  = NOP_PAYLOAD;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = ex_pl;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = ex_pl;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = ex_pl;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_PAYLOAD;
                    end
                end
                ST_SKID: begin
                    // ex_ready is low here, so only the drain side can fire
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_PAYLOAD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_PAYLOAD;
                    skid_d  = NOP_PAYLOAD;
                end
            endcase
        end
        ex_ready_d = (state_d != ST_SKID);
    end

    always_comb begin
        mem_valid = (state_q != ST_EMPTY);
        ex_ready  = ex_ready_q;
        mem_wd    = main_q.wd;
        mem_wreg  = main_q.wreg;
        mem_wdata = main_q.wdata;
        mem_hi    = main_q.hi;
        mem_lo    = main_q.lo;
        mem_whilo = main_q.whilo;
    end

`ifdef EX_MEM_MADD_EN
    logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        hilo_temp_d = '0;
        cnt_d       = '0;
        if (!flush && ex_hold) begin
            hilo_temp_d = ex_hilo_temp;
            cnt_d       = ex_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hilo_temp_o = hilo_temp_q;
    assign cnt_o       = cnt_q;
`else
    logic unused_madd;
    assign unused_madd = ^{ex_hold, ex_hilo_temp, ex_cnt};
    assign hilo_temp_o = '0;
    assign cnt_o       = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenarios plus a randomized run
// compared against a queue-based two-entry FIFO model.
`timescale 1ns/1ps
module tb_ex_mem_skid;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int PW = AW + 1 + 3*DW + 1;

    logic            clk = 1'b0;
    logic            rst, flush, ex_valid, ex_ready;
    logic [AW-1:0]   ex_wd;
    logic            ex_wreg;
    logic [DW-1:0]   ex_wdata, ex_hi, ex_lo;
    logic            ex_whilo, ex_hold;
    logic [2*DW-1:0] ex_hilo_temp;
    logic [CW-1:0]   ex_cnt;
    logic            mem_valid, mem_ready;
    logic [AW-1:0]   mem_wd;
    logic            mem_wreg;
    logic [DW-1:0]   mem_wdata, mem_hi, mem_lo;
    logic            mem_whilo;
    logic [2*DW-1:0] hilo_temp_o;
    logic [CW-1:0]   cnt_o;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] mem_pl;
    logic [PW-1:0] ex_pl;
    logic [PW-1:0] mq[$];

    always #5 clk = ~clk;

    ex_mem_skid #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_hold(ex_hold), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    assign mem_pl = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};
    assign ex_pl  = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};

    function automatic logic [PW-1:0] pl_of(input logic [DW-1:0] d, input logic [AW-1:0] wd);
        return {wd, 1'b1, d, d ^ 32'hFFFF_0000, ~d, d[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; ex_valid = 0; ex_wd = '0; ex_wreg = 0; ex_wdata = '0;
        ex_hi = '0; ex_lo = '0; ex_whilo = 0; ex_hold = 0;
        ex_hilo_temp = '0; ex_cnt = '0; mem_ready = 0;
    endtask

    task automatic set_ex(input logic [DW-1:0] d, input logic [AW-1:0] wd);
        ex_valid = 1; ex_wd = wd; ex_wreg = 1; ex_wdata = d;
        ex_hi = d ^ 32'hFFFF_0000; ex_lo = ~d; ex_whilo = d[0];
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; mem_ready = 1;
        set_ex(32'h5A, 5'd7);
        tick(); tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (mem_wd !== '0) begin errors++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
        checks++; if (mem_pl !== '0) begin errors++; $display("FAIL reset_payload got=%h exp=0", mem_pl); end
        checks++; if ({hilo_temp_o, cnt_o} !== '0) begin errors++; $display("FAIL reset_madd got=%h/%h exp=0", hilo_temp_o, cnt_o); end
        rst = 0; ex_valid = 0;
        tick();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        idle_inputs();
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_ex(vals[i], AW'(i + 1));
            tick();
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, mem_valid); end
            checks++; if (mem_pl !== pl_of(vals[i], AW'(i + 1))) begin errors++; $display("FAIL stream_payload[%0d] got=%h exp=%h", i, mem_pl, pl_of(vals[i], AW'(i + 1))); end
            checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ex_ready); end
        end
        ex_valid = 0;
        tick();
        checks++; if (mem_valid !== 1'b0 || mem_wreg !== 1'b0) begin errors++; $display("FAIL stream_drain got valid=%b wreg=%b exp=0/0", mem_valid, mem_wreg); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        set_ex(32'hA, 5'd10);
        tick();
        checks++; if (mem_pl !== pl_of(32'hA, 5'd10) || ex_ready !== 1'b1) begin errors++; $display("FAIL bp_first got=%h ready=%b exp=%h ready=1", mem_pl, ex_ready, pl_of(32'hA, 5'd10)); end
        set_ex(32'hB, 5'd11);
        tick();
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready got=%b exp=0", ex_ready); end
        checks++; if (mem_pl !== pl_of(32'hA, 5'd10)) begin errors++; $display("FAIL bp_skid_hold got=%h exp=%h", mem_pl, pl_of(32'hA, 5'd10)); end
        ex_valid = 0;
        tick();
        checks++; if (mem_pl !== pl_of(32'hA, 5'd10) || mem_valid !== 1'b1 || ex_ready !== 1'b0) begin errors++; $display("FAIL bp_stable got=%h valid=%b ready=%b exp=%h/1/0", mem_pl, mem_valid, ex_ready, pl_of(32'hA, 5'd10)); end
        mem_ready = 1;
        tick();
        checks++; if (mem_pl !== pl_of(32'hB, 5'd11) || mem_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%h valid=%b exp=%h/1", mem_pl, mem_valid, pl_of(32'hB, 5'd11)); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", ex_ready); end
        tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", mem_valid); end
    endtask

    task automatic test_flush_skid();
        idle_inputs();
        set_ex(32'hC1, 5'd3); tick();
        set_ex(32'hC2, 5'd4); tick();
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got=%b exp=0", ex_ready); end
        flush = 1; mem_ready = 1;
        set_ex(32'hC3, 5'd5);
        tick();
        checks++; if (mem_valid !== 1'b0 || mem_wreg !== 1'b0) begin errors++; $display("FAIL flush_empty got valid=%b wreg=%b exp=0/0", mem_valid, mem_wreg); end
        checks++; if (mem_pl !== '0 || ex_ready !== 1'b1) begin errors++; $display("FAIL flush_nop got=%h ready=%b exp=0/1", mem_pl, ex_ready); end
        flush = 0; ex_valid = 0;
        tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_no_deliver got=%b exp=0", mem_valid); end
    endtask

    task automatic test_madd();
        logic [2*DW-1:0] exp_t;
        logic [CW-1:0]   exp_c;
        idle_inputs();
        ex_hold = 1; ex_hilo_temp = 64'h0000_0001_FFFF_FFFF; ex_cnt = 2'd1;
        tick();
`ifdef EX_MEM_MADD_EN
        exp_t = 64'h0000_0001_FFFF_FFFF; exp_c = 2'd1;
`else
        exp_t = '0; exp_c = '0;
`endif
        checks++; if (hilo_temp_o !== exp_t || cnt_o !== exp_c) begin errors++; $display("FAIL madd_hold got=%h/%h exp=%h/%h", hilo_temp_o, cnt_o, exp_t, exp_c); end
        ex_hold = 0;
        tick();
        checks++; if (hilo_temp_o !== '0 || cnt_o !== '0) begin errors++; $display("FAIL madd_release got=%h/%h exp=0/0", hilo_temp_o, cnt_o); end
        ex_hold = 1; ex_cnt = 2'd2; tick();
        flush = 1; tick();
        checks++; if (hilo_temp_o !== '0 || cnt_o !== '0) begin errors++; $display("FAIL madd_flush got=%h/%h exp=0/0", hilo_temp_o, cnt_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        mem_ready = 1;
        set_ex(32'hD1, 5'd21); tick();
        checks++; if (mem_pl !== pl_of(32'hD1, 5'd21)) begin errors++; $display("FAIL simul_first got=%h exp=%h", mem_pl, pl_of(32'hD1, 5'd21)); end
        set_ex(32'hD2, 5'd22); tick();
        checks++; if (mem_valid !== 1'b1 || ex_ready !== 1'b1) begin errors++; $display("FAIL simul_state got valid=%b ready=%b exp=1/1", mem_valid, ex_ready); end
        checks++; if (mem_pl !== pl_of(32'hD2, 5'd22)) begin errors++; $display("FAIL simul_payload got=%h exp=%h", mem_pl, pl_of(32'hD2, 5'd22)); end
        ex_valid = 0; tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got=%b exp=0", mem_valid); end
    endtask

    task automatic test_random();
        logic            m_ready;
        logic [2*DW-1:0] m_hilo;
        logic [CW-1:0]   m_cnt;
        logic            do_in, do_out;
        logic [PW-1:0]   exp_pl;
        idle_inputs();
        rst = 1; tick(); rst = 0;
        mq.delete();
        m_ready = 1; m_hilo = '0; m_cnt = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst          = ($urandom_range(0, 63) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            ex_valid     = ($urandom_range(0, 9) < 7);
            mem_ready    = ($urandom_range(0, 9) < 7);
            ex_wd        = AW'($urandom);
            ex_wreg      = 1'($urandom);
            ex_wdata     = $urandom;
            ex_hi        = $urandom;
            ex_lo        = $urandom;
            ex_whilo     = 1'($urandom);
            ex_hold      = 1'($urandom);
            ex_hilo_temp = {$urandom, $urandom};
            ex_cnt       = CW'($urandom);
            do_out = (mq.size() > 0) && mem_ready;
            do_in  = ex_valid && m_ready;
            #1;
            if (rst || flush) begin
                mq.delete();
            end else begin
                if (do_out) void'(mq.pop_front());
                if (do_in) mq.push_back(ex_pl);
            end
`ifdef EX_MEM_MADD_EN
            m_hilo = (!rst && !flush && ex_hold) ? ex_hilo_temp : '0;
            m_cnt  = (!rst && !flush && ex_hold) ? ex_cnt : '0;
`endif
            m_ready = (mq.size() < 2);
            exp_pl  = (mq.size() > 0) ? mq[0] : '0;
            tick();
            checks++; if (mem_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, mem_valid, mq.size() > 0); end
            checks++; if (ex_ready !== m_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ex_ready, m_ready); end
            checks++; if (mem_pl !== exp_pl) begin errors++; $display("FAIL rand_payload cyc=%0d got=%h exp=%h", cyc, mem_pl, exp_pl); end
            checks++; if (hilo_temp_o !== m_hilo || cnt_o !== m_cnt) begin errors++; $display("FAIL rand_madd cyc=%0d got=%h/%h exp=%h/%h", cyc, hilo_temp_o, cnt_o, m_hilo, m_cnt); end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_skid();
        test_madd();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
